// File: rtl/ctl_pkg.sv
// Shared encodings for the multi-cycle control FSM: state codes, opcodes,
// datapath mux selects and the control word passed from decode to top.
package ctl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_ERR = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_RTYPE = 3'b100;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Every datapath control produced by the per-state decode.
  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regWrite;
    logic       regDst;
    logic       extop;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       branch;
    logic       jump;
    logic       instrDone;
  } ctrl_t;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic isSupported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Pure combinational decode from the current state (plus opcode) to the
// datapath control word. ID looks at the live opcode because opReg is only
// captured at the end of ID; later states use the captured opReg.
module mc_out_decode
  import ctl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_opReg,
  input  logic        i_zero,
  input  logic        i_memReady,
  output ctrl_t       o_ctrl
);

  // Start from all-zero controls and raise only what the current state needs.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_IF: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.aluSrcB = SRCB_FOUR;
        o_ctrl.aluOp   = ALU_ADD;
        o_ctrl.pcSrc   = PC_ALU;
        o_ctrl.pcWrite = i_memReady;
        o_ctrl.irWrite = i_memReady;
      end
      ST_ID: begin
        o_ctrl.aluSrcB = SRCB_IMMSH;
        o_ctrl.aluOp   = ALU_ADD;
        o_ctrl.extop   = 1'b1;
        if (i_op == OP_J) begin
          o_ctrl.jump      = 1'b1;
          o_ctrl.pcWrite   = 1'b1;
          o_ctrl.pcSrc     = PC_JUMP;
          o_ctrl.instrDone = 1'b1;
        end
      end
      ST_EXE: begin
        o_ctrl.aluSrcA = 1'b1;
        case (i_opReg)
          OP_RTYPE: begin
            o_ctrl.aluSrcB = SRCB_REGB;
            o_ctrl.aluOp   = ALU_RTYPE;
          end
          OP_ORI: begin
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALU_OR;
            o_ctrl.extop   = 1'b0;
          end
          OP_LW, OP_SW: begin
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALU_ADD;
            o_ctrl.extop   = 1'b1;
          end
          OP_BEQ: begin
            o_ctrl.aluSrcB   = SRCB_REGB;
            o_ctrl.aluOp     = ALU_SUB;
            o_ctrl.branch    = 1'b1;
            o_ctrl.pcSrc     = PC_ALUOUT;
            o_ctrl.pcWrite   = i_zero;
            o_ctrl.instrDone = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        o_ctrl.iorD      = 1'b1;
        o_ctrl.memRead   = (i_opReg == OP_LW);
        o_ctrl.memWrite  = (i_opReg == OP_SW);
        o_ctrl.instrDone = i_memReady && (i_opReg == OP_SW);
      end
      ST_WB: begin
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.instrDone = 1'b1;
        o_ctrl.regDst    = (i_opReg == OP_RTYPE);
        o_ctrl.memToReg  = (i_opReg == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control: holds the state register, the captured opcode and
// the sticky illegal flag, computes the next state, and drives every datapath
// control from the per-state decode. All outputs are forced low during reset.
module multi_cycle_control
  import ctl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       regDst,
  output logic       extop,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [2:0] ALUop,
  output logic [1:0] pcSrc,
  output logic       branch,
  output logic       jump,
  output logic       instrDone,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_nextState;
  logic [5:0] r_opReg;
  logic       r_illegal;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrlOut;

  // State register, opcode capture in ID, and the sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IF;
      r_opReg   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_ID) begin
        r_opReg <= OP;
      end
      if (w_nextState == ST_ERR) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state sequencing; memReady only matters while a memory access is pending.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IF: begin
        if (memReady) w_nextState = ST_ID;
      end
      ST_ID: begin
        if (OP == OP_J)            w_nextState = ST_IF;
        else if (!isSupported(OP)) w_nextState = ST_ERR;
        else                       w_nextState = ST_EXE;
      end
      ST_EXE: begin
        case (r_opReg)
          OP_RTYPE, OP_ORI: w_nextState = ST_WB;
          OP_LW, OP_SW:     w_nextState = ST_MEM;
          default:          w_nextState = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (memReady) w_nextState = (r_opReg == OP_LW) ? ST_WB : ST_IF;
      end
      ST_WB:   w_nextState = ST_IF;
      ST_ERR:  w_nextState = ST_ERR;
      default: w_nextState = ST_IF;
    endcase
  end

  mc_out_decode uDecode (
    .i_state    (r_state),
    .i_op       (OP),
    .i_opReg    (r_opReg),
    .i_zero     (zero),
    .i_memReady (memReady),
    .o_ctrl     (w_ctrl)
  );

  assign w_ctrlOut = reset ? '0 : w_ctrl;

  assign pcWrite   = w_ctrlOut.pcWrite;
  assign irWrite   = w_ctrlOut.irWrite;
  assign IorD      = w_ctrlOut.iorD;
  assign memRead   = w_ctrlOut.memRead;
  assign memWrite  = w_ctrlOut.memWrite;
  assign memToReg  = w_ctrlOut.memToReg;
  assign regWrite  = w_ctrlOut.regWrite;
  assign regDst    = w_ctrlOut.regDst;
  assign extop     = w_ctrlOut.extop;
  assign ALUsrcA   = w_ctrlOut.aluSrcA;
  assign ALUsrcB   = w_ctrlOut.aluSrcB;
  assign ALUop     = w_ctrlOut.aluOp;
  assign pcSrc     = w_ctrlOut.pcSrc;
  assign branch    = w_ctrlOut.branch;
  assign jump      = w_ctrlOut.jump;
  assign instrDone = w_ctrlOut.instrDone;
  assign illegal   = r_illegal & ~reset;

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle control FSM that sequences the shared CPU datapath (single memory port, single ALU, PC/IR/ALUOut registers) for the R-type, ori, lw, sw, beq and j instruction set. It replaces the per-instruction combinational main control with a per-state decode. It sits between the instruction register opcode field and every datapath mux and write enable. It stalls on a memory ready handshake.

## Interface
Parameters: none; all encodings are constants in the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- OP  in  6  opcode field of IR; valid from the ID state onward
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes the current access this cycle
- pcWrite  out  1  PC load enable
- irWrite  out  1  IR load enable
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- memToReg  out  1  register write data: 0=ALUOut, 1=MDR
- regWrite  out  1  register file write enable
- regDst  out  1  destination register: 0=rt, 1=rd
- extop  out  1  immediate extension: 1=sign, 0=zero
- ALUsrcA  out  1  ALU A input: 0=PC, 1=regA
- ALUsrcB  out  2  ALU B input: 00=regB, 01=4, 10=ext imm, 11=ext imm<<2
- ALUop  out  3  000=add, 001=sub, 010=or, 100=R-type (funct decode)
- pcSrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- branch  out  1  high in the beq EXE state
- jump  out  1  high in the j ID state
- instrDone  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  sticky unsupported-opcode flag

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, ERR=7. Each state holds a 3-bit registered state plus a 6-bit opReg.
- opReg is loaded from OP in ID. EXE, MEM and WB decode from opReg, not OP.
- IF:
  - memRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=add, pcSrc=00.
  - Holds while memReady=0.
  - When memReady=1: irWrite=1, pcWrite=1, then go to ID.
- ID:
  - ALUsrcA=0, ALUsrcB=11, ALUop=add, extop=1 (branch target into ALUOut).
  - j: jump=1, pcWrite=1, pcSrc=10, instrDone=1, go to IF.
  - Unsupported opcode: go to ERR.
  - Otherwise: go to EXE.
- EXE:
  - R-type: srcA=1, srcB=00, ALUop=100, then WB.
  - ori: srcA=1, srcB=10, extop=0, ALUop=or, then WB.
  - lw/sw: srcA=1, srcB=10, extop=1, ALUop=add, then MEM.
  - beq: srcA=1, srcB=00, ALUop=sub, branch=1, pcSrc=01, pcWrite=zero, instrDone=1, then IF.
- MEM:
  - IorD=1. lw asserts memRead=1; sw asserts memWrite=1.
  - Request is held while memReady=0.
  - When memReady=1: lw goes to WB; sw asserts instrDone=1 and goes to IF.
- WB:
  - regWrite=1 and instrDone=1, then go to IF.
  - R-type: regDst=1, memToReg=0.
  - ori: regDst=0, memToReg=0.
  - lw: regDst=0, memToReg=1.
- ERR: illegal=1, all other outputs 0. Stays in ERR until reset.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational from the registered state, opReg, zero and memReady. There are no output registers.
- Reset:
  - While reset=1, every output is forced to 0.
  - The next state is IF, and opReg and illegal clear to 0.
  - Reset mid-access (including during sw MEM) drops memWrite in the same cycle reset rises.
- Minimum cycles with zero-wait memory: j=2, beq=3, R/ori/sw=4, lw=5. Each memory wait cycle adds one cycle.
- memReady is sampled only in IF and MEM; it is ignored in all other states.
- memReady may be high in the first cycle of a request (zero-wait memory).
- In beq EXE, pcWrite follows zero within the same cycle.
- instrDone and the final write enable of an instruction occur in the same cycle.

## Structure
- Shared package ctl_pkg holds:
  - state encoding
  - opcode constants (000000, 001101, 100011, 101011, 000100, 000010)
  - ALUop, ALUsrcB and pcSrc encodings
- One sub-module, mc_out_decode: pure combinational state+opcode to control-word decode.
- The top level holds the state register, opReg, illegal, and next-state logic.

## Test plan
- Reset held 3 cycles with memReady=1 → all outputs 0. First cycle after release: state IF, memRead=1.
- lw, zero-wait → exactly 5 cycles. regWrite=1, memToReg=1, regDst=0 in cycle 5, with instrDone pulse.
- sw with memReady low 3 cycles in MEM → memWrite held 4 cycles, IorD=1, then IF.
- beq, OP=000100:
  - zero=1 → pcWrite=1, pcSrc=01 in cycle 3.
  - zero=0 → pcWrite=0, next state IF.
- j, OP=000010 → cycle 2: jump=1, pcWrite=1, pcSrc=10, instrDone=1.
- OP=111111 → ERR: illegal stays 1 for 20 cycles with all other outputs 0. Reset clears it.
